fp16_to_fixed: RTL and testbench

- Converts IEEE-754 binary16 values back to signed fixed-point.
- It is the inverse of the fixed-to-fp16 packer, which uses the leading-zero detectors to normalise. This block denormalises instead: it shifts the mantissa by the unbiased exponent.
- Sits on the CNN accelerator's output path, between the fp16 MAC/accumulate result stream and the int/fixed writeback.
- Two-stage pipeline with valid/ready handshake and full backpressure.

---
 rtl/fp16_pkg.sv | 37 +++
 rtl/rshift_grs.sv | 33 +++
 rtl/fp16_to_fixed.sv | 182 ++++++++++++++++++
 tb/tb_fp16_to_fixed.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// fp16 field layout, classes and helpers shared by the
// fp16 conversion blocks.
package fp16_pkg;

  localparam int FP16_EXP_W  = 5;
  localparam int FP16_MANT_W = 10;
  localparam int FP16_BIAS   = 15;
  localparam int FP16_SIG_W  = FP16_MANT_W + 1;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_MANT_W-1:0] mant;
  } fp16_t;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_DENORM,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp16_class_e;

  function automatic fp16_class_e fp16_classify(
    input fp16_t v
  );
    fp16_class_e c;
    if (v.exp == '1)
      c = (v.mant == '0) ? FP_INF : FP_NAN;
    else if (v.exp == '0)
      c = (v.mant == '0) ? FP_ZERO : FP_DENORM;
    else
      c = FP_NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/rshift_grs.sv
// Right shifter returning the kept bits plus guard,
// round and sticky for round-to-nearest-even.
module rshift_grs #(
  parameter int W  = 11,
  parameter int AW = 10
) (
  input  logic [W-1:0]  val_i,
  input  logic [AW-1:0] amt_i,
  output logic [W-1:0]  q_o,
  output logic          guard_o,
  output logic          round_o,
  output logic          sticky_o
);

  logic [2*W+1:0] ext;

  always_comb begin
    ext      = '0;
    q_o      = '0;
    guard_o  = 1'b0;
    round_o  = 1'b0;
    sticky_o = |val_i;
    // beyond W+1 every bit lands below the round bit
    if (amt_i <= AW'(W)) begin
      ext      = {val_i, {(W+2){1'b0}}} >> amt_i;
      q_o      = ext[2*W+1 -: W];
      guard_o  = ext[W+1];
      round_o  = ext[W];
      sticky_o = |ext[W-1:0];
    end
  end

endmodule

// File: rtl/fp16_to_fixed.sv
// fp16 -> signed fixed-point, two-stage valid/ready pipe.
// FP16_TO_FIXED_FLAGS_EN adds out_ovf / out_inexact.
module fp16_to_fixed
  import fp16_pkg::*;
#(
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef FP16_TO_FIXED_FLAGS_EN
  output logic                 out_ovf,
  output logic                 out_inexact,
`endif
  output logic [OUT_WIDTH-1:0] out_data
);

  localparam int SW = 10;
  localparam int LW = FP16_SIG_W + FP16_EXP_W
                    + FRAC_BITS + 1;
  localparam int MW = (LW > OUT_WIDTH + 1)
                    ? LW : OUT_WIDTH + 1;
  localparam logic signed [SW-1:0] SHIFT_OFS =
    SW'(FRAC_BITS - FP16_BIAS - FP16_MANT_W);
  localparam logic [MW-1:0] POS_MAX =
    {{(MW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [MW-1:0] NEG_LIM = POS_MAX + 1'b1;
  localparam logic [OUT_WIDTH-1:0] OMAX =
    {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OMIN =
    {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  fp16_t                  f;
  fp16_class_e            cls_d;
  logic [FP16_SIG_W-1:0]  sig_d;
  logic [FP16_EXP_W-1:0]  eexp_d;
  logic signed [SW-1:0]   shift_d;

  assign f = in_data;

  always_comb begin
    cls_d   = fp16_classify(f);
    sig_d   = {(f.exp != '0), f.mant};
    eexp_d  = (f.exp == '0) ? FP16_EXP_W'(1) : f.exp;
    shift_d = SW'(signed'({1'b0, eexp_d})) + SHIFT_OFS;
  end

  logic                  s1_valid_q;
  logic                  s1_sign_q;
  logic [FP16_SIG_W-1:0] s1_sig_q;
  logic signed [SW-1:0]  s1_shift_q;
  fp16_class_e           s1_cls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_sig_q   <= '0;
      s1_shift_q <= '0;
      s1_cls_q   <= FP_ZERO;
    end else if (en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q  <= f.sign;
        s1_sig_q   <= sig_d;
        s1_shift_q <= shift_d;
        s1_cls_q   <= cls_d;
      end
    end
  end

  logic                  neg_sh;
  logic [SW-1:0]         lamt;
  logic [SW-1:0]         ramt;
  logic [FP16_SIG_W-1:0] rq;
  logic                  rg;
  logic                  rr;
  logic                  rs;

  assign neg_sh = s1_shift_q[SW-1];
  assign lamt   = neg_sh ? '0 : s1_shift_q;
  assign ramt   = neg_sh ? SW'(-s1_shift_q) : '0;

  rshift_grs #(
    .W  (FP16_SIG_W),
    .AW (SW)
  ) u_rsh (
    .val_i    (s1_sig_q),
    .amt_i    (ramt),
    .q_o      (rq),
    .guard_o  (rg),
    .round_o  (rr),
    .sticky_o (rs)
  );

  logic [FP16_SIG_W:0]   rnd;
  logic [MW-1:0]         mag;
  logic [MW-1:0]         mag_n;
  logic [OUT_WIDTH-1:0]  res_d;
  logic                  ovf_d;
  logic                  inx_d;

  always_comb begin
    rnd   = {1'b0, rq}
          + {{FP16_SIG_W{1'b0}}, rg & (rr | rs | rq[0])};
    mag   = neg_sh ? MW'(rnd)
                   : MW'(s1_sig_q) << lamt;
    mag_n = ~mag + 1'b1;
    res_d = '0;
    ovf_d = 1'b0;
    inx_d = 1'b0;
    unique case (1'b1)
      s1_cls_q == FP_INF: begin
        res_d = s1_sign_q ? OMIN : OMAX;
        ovf_d = 1'b1;
      end
      s1_cls_q == FP_NAN:  ovf_d = 1'b1;
      s1_cls_q == FP_ZERO: res_d = '0;
      default: begin
        inx_d = neg_sh & (rg | rr | rs);
        if (!s1_sign_q && mag > POS_MAX) begin
          res_d = OMAX;
          ovf_d = 1'b1;
        end else if (s1_sign_q && mag > NEG_LIM) begin
          res_d = OMIN;
          ovf_d = 1'b1;
        end else begin
          res_d = s1_sign_q ? mag_n[OUT_WIDTH-1:0]
                            : mag[OUT_WIDTH-1:0];
        end
      end
    endcase
  end

  logic                 out_valid_q;
  logic [OUT_WIDTH-1:0] out_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q)
        out_data_q <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef FP16_TO_FIXED_FLAGS_EN
  logic ovf_q;
  logic inx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      inx_q <= 1'b0;
    end else if (en && s1_valid_q) begin
      ovf_q <= ovf_d;
      inx_q <= inx_d;
    end
  end

  assign out_ovf     = ovf_q;
  assign out_inexact = inx_q;
`else
  logic unused_flags;
  assign unused_flags = ovf_d ^ inx_d;
`endif

endmodule

// File: tb/tb_fp16_to_fixed.sv
// Directed bench for fp16_to_fixed (Q8.8 default build).
// FP16_TO_FIXED_FLAGS_EN also checks the flag outputs.
module tb_fp16_to_fixed;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef FP16_TO_FIXED_FLAGS_EN
  logic        out_ovf;
  logic        out_inexact;
`endif

  int nvec = 0;
  int nerr = 0;

  fp16_to_fixed dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FP16_TO_FIXED_FLAGS_EN
    .out_ovf     (out_ovf),
    .out_inexact (out_inexact),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    nvec++;
    assert (obs === want) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, want);
    end
  endtask

  // single isolated conversion with latency check
  task automatic one(input string tag,
                     input logic [15:0] din,
                     input logic [15:0] want);
    in_valid  = 1'b1;
    in_data   = din;
    out_ready = 1'b1;
    #1;
    chk({tag, "/rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "/lat"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "/vld"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(out_data), 32'(want));
  endtask

  logic [15:0] vin [8] = '{16'h3C00, 16'hC100,
                           16'h1E00, 16'h1A00,
                           16'hD800, 16'h5A40,
                           16'hBC00, 16'h2000};
  logic [15:0] vexp [8] = '{16'h0100, 16'hFD80,
                            16'h0002, 16'h0001,
                            16'h8000, 16'h7FFF,
                            16'hFF00, 16'h0002};

  initial begin
    int sent;
    int rcv;
    logic stall;
    logic acc;
    logic got;
    logic [15:0] held;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/vld", 32'(out_valid), 32'd0);
    chk("rst/dat", 32'(out_data), 32'd0);
    chk("rst/rdy", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // back-to-back pair
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h3C00;
    @(posedge clk); #1;
    in_data = 16'hC100;
    chk("b2b/lat", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b/v0", 32'(out_valid), 32'd1);
    chk("b2b/d0", 32'(out_data), 32'h0100);
    @(posedge clk); #1;
    chk("b2b/v1", 32'(out_valid), 32'd1);
    chk("b2b/d1", 32'(out_data), 32'hFD80);
    @(posedge clk); #1;
    chk("b2b/end", 32'(out_valid), 32'd0);

    // rounding
    one("tie0", 16'h1800, 16'h0000);
    one("tie2", 16'h1E00, 16'h0002);
    one("r075", 16'h1A00, 16'h0001);
    one("den",  16'h0001, 16'h0000);
`ifdef FP16_TO_FIXED_FLAGS_EN
    chk("den/inx", 32'(out_inexact), 32'd1);
    chk("den/ovf", 32'(out_ovf), 32'd0);
`endif
    one("ndn",  16'h8001, 16'h0000);
    one("lsb2", 16'h2000, 16'h0002);
    one("big",  16'h57FF, 16'h7FF0);
    one("m1",   16'hBC00, 16'hFF00);

    // saturation and specials
    one("p200", 16'h5A40, 16'h7FFF);
`ifdef FP16_TO_FIXED_FLAGS_EN
    chk("p200/ovf", 32'(out_ovf), 32'd1);
    chk("p200/inx", 32'(out_inexact), 32'd0);
`endif
    one("m128", 16'hD800, 16'h8000);
`ifdef FP16_TO_FIXED_FLAGS_EN
    chk("m128/ovf", 32'(out_ovf), 32'd0);
`endif
    one("fmax", 16'h7BFF, 16'h7FFF);
    one("pinf", 16'h7C00, 16'h7FFF);
    one("ninf", 16'hFC00, 16'h8000);
    one("nan",  16'h7E00, 16'h0000);
`ifdef FP16_TO_FIXED_FLAGS_EN
    chk("nan/ovf", 32'(out_ovf), 32'd1);
`endif
    one("nnan", 16'hFE00, 16'h0000);
    one("nz",   16'h8000, 16'h0000);
    one("pz",   16'h0000, 16'h0000);

    // backpressure stream
    @(posedge clk); #1;
    sent  = 0;
    rcv   = 0;
    stall = 1'b0;
    held  = '0;
    for (int c = 0; c < 300 && rcv < 8; c++) begin
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? vin[sent[2:0]] : 16'h0;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (stall) begin
        chk("bp/hold_v", 32'(out_valid), 32'd1);
        chk("bp/hold_d", 32'(out_data), 32'(held));
      end
      chk("bp/rdy", 32'(in_ready),
          32'(!out_valid || out_ready));
      acc   = in_valid && in_ready;
      got   = out_valid && out_ready;
      if (got)
        chk($sformatf("bp/d%0d", rcv),
            32'(out_data), 32'(vexp[rcv[2:0]]));
      stall = out_valid && !out_ready;
      held  = out_data;
      @(posedge clk); #1;
      if (acc) sent++;
      if (got) rcv++;
    end
    chk("bp/count", 32'(rcv), 32'd8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp/dup", 32'(out_valid), 32'd0);

    // reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h5A40;
    @(posedge clk); #1;
    in_data = 16'hC100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rs/full", 32'(out_valid), 32'd1);
    chk("rs/stall", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rs/vld", 32'(out_valid), 32'd0);
    chk("rs/dat", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hBC00;
    #1;
    chk("rs/rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rs/lat", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("rs/nv", 32'(out_valid), 32'd1);
    chk("rs/nd", 32'(out_data), 32'hFF00);
    @(posedge clk); #1;
    chk("rs/gone", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rs/gone2", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
